// File: rtl/daes_iter_ctrl.sv
// Iterative AES-128 decrypt sequencer: expands the key schedule once per key load, then drives a
// shared inverse-round unit ten times per block. Define DAES_CTRL_STATS_EN to add the blk_count output.
module daes_iter_ctrl #(
  parameter int NR  = 10,
  parameter int RCW = 4
) (
`ifdef DAES_CTRL_STATS_EN
  output logic [15:0]    blk_count,
`endif
  input  logic           clk,
  input  logic           rst,
  input  logic           key_load,
  input  logic [127:0]   key_in,
  output logic           key_ready,
  output logic           key_valid,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   ciphertext,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   plaintext,
  output logic [127:0]   ks_in,
  output logic [RCW-1:0] ks_rc,
  input  logic [127:0]   ks_out,
  output logic [127:0]   rd_data,
  output logic [127:0]   rd_key,
  output logic           rd_final,
  input  logic [127:0]   rd_out
);
  typedef enum logic [2:0] {IDLE, KEXP, READY, ROUND, DONE} state_e;

  state_e       state_q, state_d;
  logic [127:0] rk_q [0:NR];
  logic [127:0] rk_d [0:NR];
  logic [3:0]   kcnt_q, kcnt_d, rcnt_q, rcnt_d;
  logic [127:0] st_q, st_d, pt_q, pt_d;
  logic         ov_q, ov_d, kv_q, kv_d;
  logic [3:0]   kidx, ridx;

  assign kidx = kcnt_q + 4'd1;
  assign ridx = 4'(NR) - rcnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      kcnt_q  <= '0;
      rcnt_q  <= '0;
      st_q    <= '0;
      pt_q    <= '0;
      ov_q    <= 1'b0;
      kv_q    <= 1'b0;
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      kcnt_q  <= kcnt_d;
      rcnt_q  <= rcnt_d;
      st_q    <= st_d;
      pt_q    <= pt_d;
      ov_q    <= ov_d;
      kv_q    <= kv_d;
      rk_q    <= rk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kcnt_d  = kcnt_q;
    rcnt_d  = rcnt_q;
    st_d    = st_q;
    pt_d    = pt_q;
    ov_d    = ov_q;
    kv_d    = kv_q;
    rk_d    = rk_q;
    case (state_q)
      IDLE: begin
        if (key_load) begin
          rk_d[0] = key_in;
          kcnt_d  = '0;
          state_d = KEXP;
        end
      end
      KEXP: begin
        rk_d[kidx] = ks_out;
        kcnt_d     = kidx;
        if (kcnt_q == 4'(NR - 1)) begin
          kv_d    = 1'b1;
          state_d = READY;
        end
      end
      READY: begin
        // a new key wins over a block offered in the same cycle
        if (key_load) begin
          rk_d[0] = key_in;
          kcnt_d  = '0;
          kv_d    = 1'b0;
          state_d = KEXP;
        end else if (in_valid) begin
          st_d    = ciphertext ^ rk_q[NR];
          rcnt_d  = 4'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        st_d = rd_out;
        if (rcnt_q == 4'(NR)) begin
          pt_d    = rd_out;
          ov_d    = 1'b1;
          state_d = DONE;
        end else begin
          rcnt_d = rcnt_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = READY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // shared-unit buses stay at zero outside the states that own them
  always_comb begin
    key_ready = 1'b0;
    in_ready  = 1'b0;
    ks_in     = '0;
    ks_rc     = '0;
    rd_data   = '0;
    rd_key    = '0;
    rd_final  = 1'b0;
    case (state_q)
      IDLE:  key_ready = !rst;
      KEXP: begin
        ks_in = rk_q[kcnt_q];
        ks_rc = RCW'(kcnt_q);
      end
      READY: begin
        key_ready = 1'b1;
        in_ready  = 1'b1;
      end
      ROUND: begin
        rd_data  = st_q;
        rd_key   = rk_q[ridx];
        rd_final = (rcnt_q == 4'(NR));
      end
      default: ;
    endcase
  end

  assign key_valid = kv_q;
  assign out_valid = ov_q;
  assign plaintext = pt_q;

`ifdef DAES_CTRL_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (key_load && (state_q == IDLE || state_q == READY)) cnt_d = '0;
    else if (state_q == DONE && out_ready && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign blk_count = cnt_q;
`endif
endmodule

// File: tb/tb_daes_iter_ctrl.sv
// Bench for daes_iter_ctrl: behavioural AES key-step and inverse-round units close the loop,
// a queue scoreboard checks plaintext and latency against FIPS-197 vectors.
module tb_daes_iter_ctrl;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk = 1'b0, rst = 1'b1, key_load = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [127:0] key_in = '0, ciphertext = '0, exp_pt = '0;
  logic key_ready, key_valid, in_ready, out_valid, rd_final;
  logic [127:0] plaintext, ks_in, ks_out, rd_data, rd_key, rd_out;
  logic [3:0] ks_rc;
`ifdef DAES_CTRL_STATS_EN
  logic [15:0] blk_count;
`endif

  daes_iter_ctrl dut (
`ifdef DAES_CTRL_STATS_EN
    .blk_count(blk_count),
`endif
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in), .key_ready(key_ready),
    .key_valid(key_valid), .in_valid(in_valid), .in_ready(in_ready), .ciphertext(ciphertext),
    .out_valid(out_valid), .out_ready(out_ready), .plaintext(plaintext), .ks_in(ks_in),
    .ks_rc(ks_rc), .ks_out(ks_out), .rd_data(rd_data), .rd_key(rd_key), .rd_final(rd_final),
    .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  // ---------------- AES reference units ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gm(r, a);
    return r;
  endfunction
  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] y;
    y = ginv(b);
    return y ^ rl(y, 1) ^ rl(y, 2) ^ rl(y, 3) ^ rl(y, 4) ^ 8'h63;
  endfunction
  function automatic logic [7:0] isbox(input logic [7:0] b);
    return ginv(rl(b, 1) ^ rl(b, 3) ^ rl(b, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [3:0] rc);
    logic [31:0] w [4];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < int'(rc); i++) rcon = xt(rcon);
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    t = {sbox(w[3][23:16]), sbox(w[3][15:8]), sbox(w[3][7:0]), sbox(w[3][31:24])} ^ {rcon, 24'h0};
    w[0] ^= t; w[1] ^= w[0]; w[2] ^= w[1]; w[3] ^= w[2];
    return {w[0], w[1], w[2], w[3]};
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] d, input logic [127:0] k,
                                             input logic f);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        a[4*c+rr] = isbox(d[127-8*(4*((c-rr+4)%4)+rr) -: 8]);
    for (int i = 0; i < 16; i++) a[i] ^= k[127-8*i -: 8];
    for (int c = 0; c < 4; c++) begin
      if (f) begin
        for (int rr = 0; rr < 4; rr++) b[4*c+rr] = a[4*c+rr];
      end else begin
        b[4*c+0] = gm(a[4*c],8'h0e) ^ gm(a[4*c+1],8'h0b) ^ gm(a[4*c+2],8'h0d) ^ gm(a[4*c+3],8'h09);
        b[4*c+1] = gm(a[4*c],8'h09) ^ gm(a[4*c+1],8'h0e) ^ gm(a[4*c+2],8'h0b) ^ gm(a[4*c+3],8'h0d);
        b[4*c+2] = gm(a[4*c],8'h0d) ^ gm(a[4*c+1],8'h09) ^ gm(a[4*c+2],8'h0e) ^ gm(a[4*c+3],8'h0b);
        b[4*c+3] = gm(a[4*c],8'h0b) ^ gm(a[4*c+1],8'h0d) ^ gm(a[4*c+2],8'h09) ^ gm(a[4*c+3],8'h0e);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r;
  endfunction

  assign ks_out = key_step(ks_in, ks_rc);
  assign rd_out = inv_round(rd_data, rd_key, rd_final);

  // ---------------- checking ----------------
  int n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct { logic [127:0] pt; int t_acc; } sb_t;
  sb_t sb_q[$];
  sb_t e;
  int  rise_q[$];
  int  cyc = 0, n_acc = 0, n_xfer = 0;
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        rise_q.push_back(cyc);
        chk("ov_rise_expected", 128'(sb_q.size() != 0), 128'd1);
        if (sb_q.size() != 0) chk("latency", 128'(cyc - sb_q[0].t_acc), 128'd10);
      end
      ov_prev = out_valid;
      if (out_valid && out_ready) begin
        n_xfer++;
        chk("xfer_expected", 128'(sb_q.size() != 0), 128'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("plaintext", plaintext, e.pt);
        end
      end
      if (in_valid && in_ready && !key_load) begin
        sb_q.push_back('{pt: exp_pt, t_acc: cyc + 1});
        n_acc++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
    chk(tag, 128'(sb_q.size()), 128'd0);
  endtask

  task automatic wait_kv(input string tag);
    int n;
    n = 0;
    while (!key_valid && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 128'(n), 128'd10);
  endtask

  initial begin
    int a0, r0, x0;
    // reset state
    @(negedge clk);
    chk("rst_key_ready", key_ready, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_plaintext", plaintext, 0);
    chk("rst_buses", ks_in | rd_data | rd_key, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_key_ready", key_ready, 1);
    chk("idle_in_ready", in_ready, 0);

    // key load (block offered in IDLE must be ignored)
    tick();
    key_load = 1'b1; key_in = K1; in_valid = 1'b1; ciphertext = C1; exp_pt = P1;
    tick();
    key_load = 1'b0; in_valid = 1'b0;
    chk("kexp_ks_in0", ks_in, K1);
    chk("kexp_key_ready", key_ready, 0);
    chk("kexp_key_valid", key_valid, 0);
    wait_kv("kv_latency_k1");
    chk("ready_in_ready", in_ready, 1);
    chk("idle_block_ignored", 128'(n_acc), 128'd0);

    // single block, FIPS-197 C.1
    tick();
    ciphertext = C1; exp_pt = P1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    drain("drain_single");

    // backpressure
    tick();
    out_ready = 1'b0; ciphertext = C1; exp_pt = P1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 30 && !out_valid; i++) @(negedge clk);
    chk("bp_out_valid", out_valid, 1);
    x0 = n_xfer;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_pt", plaintext, P1);
      chk("bp_hold_ov", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_key_ready", key_ready, 0);
    end
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_single_xfer", 128'(n_xfer - x0), 128'd1);
    chk("bp_ov_low", out_valid, 0);
    chk("bp_ready_again", in_ready, 1);

    // back-to-back
    tick();
    a0 = n_acc; r0 = rise_q.size();
    out_ready = 1'b1; ciphertext = C1; exp_pt = P1; in_valid = 1'b1;
    for (int i = 0; i < 100 && n_acc < a0 + 3; i++) @(negedge clk);
    tick();
    in_valid = 1'b0;
    drain("drain_b2b");
    chk("b2b_accepts", 128'(n_acc - a0), 128'd3);
    chk("b2b_rises", 128'(rise_q.size() - r0), 128'd3);
    if (rise_q.size() >= r0 + 3) begin
      chk("b2b_gap1", 128'(rise_q[r0+1] - rise_q[r0]), 128'd12);
      chk("b2b_gap2", 128'(rise_q[r0+2] - rise_q[r0+1]), 128'd12);
    end
`ifdef DAES_CTRL_STATS_EN
    chk("stats_count", 128'(blk_count), 128'(n_xfer));
`endif

    // key_load wins over simultaneous in_valid
    tick();
    a0 = n_acc;
    key_load = 1'b1; key_in = K2; in_valid = 1'b1; ciphertext = C1; exp_pt = P1;
    tick();
    key_load = 1'b0; in_valid = 1'b0;
`ifdef DAES_CTRL_STATS_EN
    chk("stats_cleared", 128'(blk_count), 128'd0);
`endif
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("kp_kv_low", key_valid, 0);
      chk("kp_no_out", out_valid, 0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("kp_kv_high", key_valid, 1);
    chk("kp_no_accept", 128'(n_acc - a0), 128'd0);
    tick();
    ciphertext = C2; exp_pt = P2; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    drain("drain_k2");

    // reset in the middle of round 5
    tick();
    ciphertext = C2; exp_pt = P2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("mid_round_active", rd_final, 0);
    rst = 1'b1;
    #1;
    chk("mr_key_valid", key_valid, 0);
    chk("mr_key_ready", key_ready, 0);
    chk("mr_in_ready", in_ready, 0);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_plaintext", plaintext, 0);
    chk("mr_rd_bus", rd_data | rd_key, 0);
    chk("mr_rd_final", rd_final, 0);
    chk("mr_ks_bus", ks_in | 128'(ks_rc), 0);
    tick();
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 0);
      chk("post_rst_key_valid", key_valid, 0);
    end
    tick();
    key_load = 1'b1; key_in = K1;
    tick();
    key_load = 1'b0;
    wait_kv("kv_latency_reload");
    chk("reload_in_ready", in_ready, 1);
    tick();
    ciphertext = C1; exp_pt = P1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drain("drain_reload");

    @(negedge clk);
    chk("sb_empty", 128'(sb_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
    $fatal(1);
  end
endmodule

// File: doc/daes_iter_ctrl.md
Name: daes_iter_ctrl

Overview:
- Sequencer for an area-reduced AES-128 decryptor that reuses one inverse-round datapath and one key-expansion step unit, instead of ten unrolled instances of each.
- Expands and stores the round-key schedule once per key load.
- Then runs each ciphertext block through 11 key additions over 10 iterative round cycles.
- Uses valid/ready handshakes on the block input and output; sits between the host interface and the shared round/key-step units.

Parameters:
- NR, 10, number of AES rounds; only 10 (AES-128) is supported.
- RCW, 4, width of the round-constant index driven to the key-step unit.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_load  in  1  one-cycle request to load key_in.
- key_in  in  128  cipher key.
- key_ready  out  1  high when key_load will be accepted (states IDLE, READY).
- key_valid  out  1  high once a complete schedule is stored.
- in_valid  in  1  ciphertext block valid.
- in_ready  out  1  high only in state READY.
- ciphertext  in  128  input block.
- out_valid  out  1  plaintext valid.
- out_ready  in  1  consumer accepts plaintext.
- plaintext  out  128  result; held stable while out_valid && !out_ready.
- ks_in  out  128  previous round key, to the key-step unit.
- ks_rc  out  RCW  round-constant index (0..9), to the key-step unit.
- ks_out  in  128  next round key (combinational return).
- rd_data  out  128  round state, to the inverse-round unit.
- rd_key  out  128  round key, to the inverse-round unit.
- rd_final  out  1  final round: omit InvMixColumns.
- rd_out  in  128  round result (combinational return).

Behaviour:
- Reset values: all outputs 0, state IDLE, key_valid 0, schedule registers rk[0..10] = 0, round counter 0.
- States: IDLE, KEXP, READY, ROUND, DONE.
- IDLE:
  - key_ready=1.
  - key_load -> rk[0]<=key_in, kcnt<=0, go to KEXP.
  - in_valid is ignored (in_ready=0).
- KEXP (10 cycles, kcnt 0..9):
  - ks_in=rk[kcnt], ks_rc=kcnt.
  - Each cycle: rk[kcnt+1]<=ks_out; at kcnt=9 set key_valid=1 and go to READY.
  - key_valid is 0 throughout KEXP.
  - key_load during KEXP is ignored.
- READY:
  - in_ready=1, key_ready=1.
  - in_valid -> state_reg<=ciphertext^rk[10], rcnt<=1, go to ROUND.
  - key_load takes priority over simultaneous in_valid: block not accepted, go to KEXP.
- ROUND (10 cycles, rcnt 1..10):
  - rd_data=state_reg, rd_key=rk[NR-rcnt], rd_final=(rcnt==10).
  - Each cycle: state_reg<=rd_out.
  - At rcnt=10: plaintext<=rd_out, out_valid<=1, go to DONE.
- DONE:
  - Hold plaintext and out_valid until out_ready.
  - On out_ready: out_valid<=0, go to READY (in_ready rises the next cycle).
  - key_load is ignored (key_ready=0).
- Latency: input accepted at edge T -> out_valid high after edge T+10 (10 round cycles). Maximum throughput is one block per 12 cycles.
- ks_in, ks_rc, rd_* are 0 outside their active states, so the shared units see a quiet bus.
- rst asserted mid-operation (any state): immediate return to reset values. The schedule is lost, key_valid=0, and any block in flight is dropped.
- Arithmetic: counters are 4-bit and never wrap; key addition is bitwise XOR; no carries.

Optional Feature:
- Macro: DAES_CTRL_STATS_EN.
- With the macro defined:
  - Adds output blk_count [15:0]; reset 0.
  - Increments on each DONE->READY transfer; saturates at 16'hFFFF.
  - Cleared by an accepted key_load.
- Without the macro: port and counter absent; all other behaviour identical.

Test Plan:
- FIPS-197 C.1, real key-step/inverse-round units attached:
  - key_load with key 000102030405060708090a0b0c0d0e0f -> key_valid rises exactly 10 cycles later.
  - Ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff with out_valid 10 cycles after acceptance.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> plaintext stable, in_ready=0 throughout, a single transfer on release.
- Back-to-back: 3 blocks with in_valid and out_ready held high -> 3 correct plaintexts, spaced 12 cycles apart.
- Key change priority: key_load and in_valid together in READY -> no block accepted, key_valid=0 for 10 cycles; new key 2b7e151628aed2a6abf7158809cf4f3c then decrypts 3925841d02dc09fbdc118597196a0b32 to 3243f6a8885a308d313198a2e0370734.
- Reset mid-round: assert rst at round 5 -> all outputs 0 immediately, key_valid=0, in_ready=0 until a new key expansion completes.
- With DAES_CTRL_STATS_EN: 3 blocks -> blk_count=3; key_load -> blk_count=0.
